dpram_client: RTL and testbench

Single-port initiator that drives one port of the team's dual-port block RAM (synchronous read, 1-cycle RAM latency, WRITE_FIRST, no output register).
- Accepts a valid/ready request stream from core logic (CPU or video fetch).
- Registers all RAM port signals and returns read data with a fixed-latency response strobe.
- Contains a clear sequencer that fills the whole RAM with a constant after reset or on command, so arcade RAMs start deterministic.

---
 rtl/dpram_client.sv | 133 +++++++++++++
 tb/tb_dpram_client.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_client.sv
// Single-port initiator for one port of a dual-port block RAM (1-cycle synchronous read).
// Registers every RAM port signal, returns reads with a fixed 2-cycle latency and can sweep-clear the RAM.
module dpram_client #(
  parameter int                     addr_width_g     = 8,
  parameter int                     data_width_g     = 8,
  parameter bit                     clear_on_reset_g = 1'b1,
  parameter logic [data_width_g-1:0] clear_value_g   = {data_width_g{1'b0}}
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [addr_width_g-1:0] req_addr,
  input  logic [data_width_g-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [data_width_g-1:0] rsp_rdata,
  input  logic                    clear_start,
  output logic                    busy,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t                  RESET_STATE = clear_on_reset_g ? ST_CLEAR : ST_RUN;
  localparam logic [addr_width_g-1:0] LAST_ADDR   = {addr_width_g{1'b1}};
  localparam logic [addr_width_g-1:0] ADDR_ONE    = {{(addr_width_g-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [addr_width_g-1:0] cnt_q, cnt_d;
  logic [addr_width_g-1:0] addr_q, addr_d;
  logic [data_width_g-1:0] data_q, data_d;
  logic                    wren_q, wren_d;
  logic                    rd1_q, rd1_d;
  logic                    rd2_q;
  logic                    rsp_valid_q;
  logic [data_width_g-1:0] rsp_rdata_q;

  // Next-state decode: request issue in RUN, one clear write per cycle in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    rd1_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_wdata;
          wren_d = req_we;
          rd1_d  = ~req_we;
        end else begin
          wren_d = 1'b0;
        end
        // A request on the same edge is still issued; the sweep starts on the following edge.
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = {addr_width_g{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        addr_d = cnt_q;
        data_d = clear_value_g;
        wren_d = 1'b1;
        cnt_d  = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = {addr_width_g{1'b0}};
      end
    endcase
  end

  // State, sweep counter and registered RAM port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= {addr_width_g{1'b0}};
      addr_q  <= {addr_width_g{1'b0}};
      data_q  <= {data_width_g{1'b0}};
      wren_q  <= 1'b0;
      rd1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      rd1_q   <= rd1_d;
    end
  end

  // Read response pipeline: RAM samples one edge after issue, data captured the edge after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd2_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {data_width_g{1'b0}};
    end else begin
      rd2_q       <= rd1_q;
      rsp_valid_q <= rd2_q;
      if (rd2_q) begin
        rsp_rdata_q <= ram_q;
      end else begin
        rsp_rdata_q <= rsp_rdata_q;
      end
    end
  end

  assign req_ready   = (state_q == ST_RUN);
  assign busy        = (state_q == ST_CLEAR);
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dpram_client.sv
// Directed bench for dpram_client: two instances (clear-on-reset and start-in-RUN),
// each paired with a behavioural 1-cycle WRITE_FIRST synchronous RAM.
module tb_dpram_client;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [7:0] CV = 8'hA5;

  logic clk;
  logic reset_n;

  logic          req_valid, req_we, clear_start;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, busy, ram_wren;
  logic [DW-1:0] rsp_rdata, ram_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q;

  logic          req_valid0, req_we0, clear_start0;
  logic [AW-1:0] req_addr0;
  logic [DW-1:0] req_wdata0;
  logic          req_ready0, rsp_valid0, busy0, ram_wren0;
  logic [DW-1:0] rsp_rdata0, ram_data0;
  logic [AW-1:0] ram_address0;
  logic [DW-1:0] ram_q0;

  logic [DW-1:0] mem  [0:15];
  logic [DW-1:0] mem0 [0:15];
  logic [DW-1:0] pre  [0:15];
  logic [DW-1:0] pre0 [0:15];
  logic          init_done;

  int n_cmp;
  int n_err;
  int rsp_cnt;
  logic [DW-1:0] rsp_q[$];

  dpram_client #(.addr_width_g(AW), .data_width_g(DW), .clear_on_reset_g(1'b1), .clear_value_g(CV)) u_dut (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_start(clear_start), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  dpram_client #(.addr_width_g(AW), .data_width_g(DW), .clear_on_reset_g(1'b0), .clear_value_g(CV)) u_dut0 (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .clear_start(clear_start0), .busy(busy0),
    .ram_address(ram_address0), .ram_data(ram_data0), .ram_wren(ram_wren0), .ram_q(ram_q0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAMs, loaded from the preload tables on the first edges.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= pre[i];
        mem0[i] <= pre0[i];
      end
    end else begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= ram_wren ? ram_data : mem[ram_address];
      if (ram_wren0) mem0[ram_address0] <= ram_data0;
      ram_q0 <= ram_wren0 ? ram_data0 : mem0[ram_address0];
    end
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_q.push_back(rsp_rdata);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      check({tag, "_wren"}, {31'd0, ram_wren}, 32'd1);
      check({tag, "_addr"}, {28'd0, ram_address}, i);
      check({tag, "_data"}, {24'd0, ram_data}, {24'd0, CV});
      check({tag, "_busy"}, {31'd0, busy}, (i < 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_all(input string tag, input logic [7:0] exp);
    rsp_q.delete();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(i);
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();
    check({tag, "_count"}, rsp_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < rsp_q.size(); i++) begin
      check({tag, "_data"}, {24'd0, rsp_q[i]}, {24'd0, exp});
    end
  endtask

  task automatic write_req(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int cnt_before;
    n_cmp = 0; n_err = 0; rsp_cnt = 0;
    init_done = 1'b0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; clear_start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pre[i]  = 8'($urandom_range(0, 255));
      pre0[i] = 8'($urandom_range(0, 255));
    end
    step();
    init_done = 1'b1;
    step();
    step();

    // 1: reset state, clear-on-reset sweep and readback
    check("rst_busy",  {31'd0, busy}, 32'd1);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_wren",  {31'd0, ram_wren}, 32'd0);
    check("rst_addr",  {28'd0, ram_address}, 32'd0);
    check("rst_data",  {24'd0, ram_data}, 32'd0);
    check("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    check("rst_rspd",  {24'd0, rsp_rdata}, 32'd0);
    check("rst0_ready", {31'd0, req_ready0}, 32'd1);
    check("rst0_busy",  {31'd0, busy0}, 32'd0);
    reset_n = 1'b1;
    check("rel_busy", {31'd0, busy}, 32'd1);
    check_sweep("sweep1");
    check("post1_ready", {31'd0, req_ready}, 32'd1);
    check("post1_0_ready", {31'd0, req_ready0}, 32'd1);
    check("post1_0_busy", {31'd0, busy0}, 32'd0);
    step();
    check("post1_wren", {31'd0, ram_wren}, 32'd0);
    read_all("read1", CV);

    // 2: write then read same address in consecutive cycles
    write_req(4'd3, 8'h3C);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    step();
    req_valid = 1'b0;
    check("raw_addr", {28'd0, ram_address}, 32'd3);
    check("raw_wren", {31'd0, ram_wren}, 32'd0);
    step();
    check("raw_rspv_early", {31'd0, rsp_valid}, 32'd0);
    step();
    check("raw_rspv", {31'd0, rsp_valid}, 32'd1);
    check("raw_rspd", {24'd0, rsp_rdata}, 32'h3C);
    step();
    check("raw_rspv_late", {31'd0, rsp_valid}, 32'd0);
    check("raw_hold", {24'd0, rsp_rdata}, 32'h3C);

    // 3: back-to-back reads
    write_req(4'd1, 8'h11);
    write_req(4'd2, 8'h22);
    write_req(4'd3, 8'h33);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    step();
    req_addr = 4'd2;
    step();
    check("b2b_rspv0", {31'd0, rsp_valid}, 32'd0);
    req_addr = 4'd3;
    step();
    req_valid = 1'b0;
    check("b2b_rspv1", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rspd1", {24'd0, rsp_rdata}, 32'h11);
    step();
    check("b2b_rspv2", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rspd2", {24'd0, rsp_rdata}, 32'h22);
    step();
    check("b2b_rspv3", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rspd3", {24'd0, rsp_rdata}, 32'h33);
    step();
    check("b2b_rspv4", {31'd0, rsp_valid}, 32'd0);

    // 4: read with clear_start on the same edge, second clear_start mid-sweep
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; clear_start = 1'b1;
    step();
    req_valid = 1'b0; clear_start = 1'b0;
    check("cs_busy", {31'd0, busy}, 32'd1);
    check("cs_ready", {31'd0, req_ready}, 32'd0);
    check("cs_addr", {28'd0, ram_address}, 32'd3);
    check("cs_wren", {31'd0, ram_wren}, 32'd0);
    step();
    check("cs_rspv_early", {31'd0, rsp_valid}, 32'd0);
    check("cs_first_addr", {28'd0, ram_address}, 32'd0);
    step();
    check("cs_rspv", {31'd0, rsp_valid}, 32'd1);
    check("cs_rspd", {24'd0, rsp_rdata}, 32'h33);
    check("cs_rsp_busy", {31'd0, busy}, 32'd1);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    busy_cnt = 4;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
    end
    check("cs_busy_len", busy_cnt, 32'd16);
    read_all("read4", CV);

    // 5a: reset with a read in flight
    write_req(4'd7, 8'h77);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
    step();
    req_valid = 1'b0;
    cnt_before = rsp_cnt;
    reset_n = 1'b0;
    #1;
    check("rf_wren", {31'd0, ram_wren}, 32'd0);
    check("rf_addr", {28'd0, ram_address}, 32'd0);
    check("rf_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    reset_n = 1'b1;
    check_sweep("sweep5a");
    step();
    step();
    check("rf_no_rsp", rsp_cnt, cnt_before);

    // 5b: reset mid-sweep with counter at 7
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (7) step();
    check("mid_addr", {28'd0, ram_address}, 32'd6);
    check("mid_wren", {31'd0, ram_wren}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wren", {31'd0, ram_wren}, 32'd0);
    check("mid_rst_addr", {28'd0, ram_address}, 32'd0);
    check("mid_rst_data", {24'd0, ram_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    reset_n = 1'b1;
    check_sweep("sweep5b");

    // 6: start-in-RUN instance left its RAM untouched, then accepts a write
    check("run0_ready", {31'd0, req_ready0}, 32'd1);
    check("run0_busy", {31'd0, busy0}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("run0_mem", {24'd0, mem0[i]}, {24'd0, pre0[i]});
    end
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 4'd5; req_wdata0 = 8'h5E;
    step();
    req_valid0 = 1'b0; req_we0 = 1'b0;
    check("run0_wren", {31'd0, ram_wren0}, 32'd1);
    step();
    check("run0_write", {24'd0, mem0[5]}, 32'h5E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
